dino_game_sequencer: RTL and testbench

Game-level sequencer for the dinosaur runner. Sits between the player button / frame timing and the `block_controller` rendering datapath. It owns the INI/PLAY/DONE game state, schedules obstacle spawns from an LFSR, issues one-shot jump commands, and maintains the running score and scroll speed consumed by the datapath and the seven-segment display.

---
 rtl/dino_game_sequencer.sv | 142 ++++++++++++++
 tb/tb_dino_game_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_sequencer.sv
// Game-level sequencer for the dinosaur runner: INI/PLAY/DONE control, jump timing,
// LFSR-driven obstacle spawning, and score/scroll-speed bookkeeping for the datapath.
module dino_game_sequencer #(
  parameter int          JUMP_FRAMES = 32,
  parameter int          MIN_GAP     = 40,
  parameter int          SPEED_STEP  = 512,
  parameter int          SPEED_MAX   = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        up,
  input  logic        collision,
  output logic [1:0]  state,
  output logic        jump_start,
  output logic        airborne,
  output logic        spawn,
  output logic [1:0]  spawn_kind,
  output logic [3:0]  speed,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    INI  = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } gameState_e;

  gameState_e  state_q, state_d;
  logic        up_q;
  logic        upRise;
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsrFb;
  logic [7:0]  airCnt_q, airCnt_d;
  logic        airborne_q, airborne_d;
  logic [7:0]  countdown_q, countdown_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  speed_q, speed_d;
  logic [15:0] speedQuot;
  logic        jumpStart_q, jumpStart_d;
  logic        spawn_q, spawn_d;
  logic [1:0]  spawnKind_q, spawnKind_d;

  assign upRise = up & ~up_q;
  assign lfsrFb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A collision in PLAY freezes every other update in that cycle.
  always_comb begin
    state_d     = state_q;
    airCnt_d    = airCnt_q;
    airborne_d  = airborne_q;
    countdown_d = countdown_q;
    score_d     = score_q;
    speed_d     = speed_q;
    speedQuot   = '0;
    jumpStart_d = 1'b0;
    spawn_d     = 1'b0;
    spawnKind_d = spawnKind_q;
    lfsr_d      = (lfsr_q == 16'd0) ? LFSR_SEED : {lfsr_q[14:0], lfsrFb};

    case (state_q)
      INI: begin
        if (upRise) begin
          state_d     = PLAY;
          score_d     = 16'd0;
          speed_d     = 4'd1;
          countdown_d = 8'(MIN_GAP);
        end
      end
      PLAY: begin
        if (collision) begin
          state_d = DONE;
        end else begin
          if (upRise && !airborne_q) begin
            jumpStart_d = 1'b1;
            airborne_d  = 1'b1;
            airCnt_d    = 8'(JUMP_FRAMES);
          end else if (frame_tick && (airCnt_q != 8'd0)) begin
            airCnt_d = airCnt_q - 8'd1;
            if (airCnt_q == 8'd1) airborne_d = 1'b0;
          end
          if (frame_tick) begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            // Speed tracks the score value being written on this same edge.
            speedQuot = score_d / 16'(SPEED_STEP);
            if (speedQuot >= 16'(SPEED_MAX - 1)) speed_d = 4'(SPEED_MAX);
            else                                  speed_d = speedQuot[3:0] + 4'd1;
            if (countdown_q == 8'd0) begin
              spawn_d     = 1'b1;
              spawnKind_d = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
              countdown_d = 8'(MIN_GAP) + {3'b000, lfsr_q[4:0]};
            end else begin
              countdown_d = countdown_q - 8'd1;
            end
          end
        end
      end
      DONE: begin
        if (upRise) state_d = INI;
      end
      default: state_d = INI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INI;
      up_q        <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      airCnt_q    <= 8'd0;
      airborne_q  <= 1'b0;
      countdown_q <= 8'(MIN_GAP);
      score_q     <= 16'd0;
      speed_q     <= 4'd1;
      jumpStart_q <= 1'b0;
      spawn_q     <= 1'b0;
      spawnKind_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      up_q        <= up;
      lfsr_q      <= lfsr_d;
      airCnt_q    <= airCnt_d;
      airborne_q  <= airborne_d;
      countdown_q <= countdown_d;
      score_q     <= score_d;
      speed_q     <= speed_d;
      jumpStart_q <= jumpStart_d;
      spawn_q     <= spawn_d;
      spawnKind_q <= spawnKind_d;
    end
  end

  assign state      = state_q;
  assign jump_start = jumpStart_q;
  assign airborne   = airborne_q;
  assign spawn      = spawn_q;
  assign spawn_kind = spawnKind_q;
  assign speed      = speed_q;
  assign score      = score_q;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Scoreboard bench for dino_game_sequencer: a behavioural game model predicts every
// cycle's outputs, plus directed checks on start, jump, spawn, collision and saturation.
module tb_dino_game_sequencer;

  localparam int          JF   = 4;
  localparam int          MG   = 40;
  localparam int          SS   = 4;
  localparam int          SM   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        up;
  logic        collision;
  logic [1:0]  state;
  logic        jump_start;
  logic        airborne;
  logic        spawn;
  logic [1:0]  spawn_kind;
  logic [3:0]  speed;
  logic [15:0] score;

  int total = 0;
  int bad   = 0;
  logic [26:0] expQ[$];

  int   mState, mLfsr, mAir, mCd, mScore, mSpeed, mKind;
  logic mUpQ, mAirborne, mJump, mSpawn;

  int tickIdx;
  int firstSpawn;
  int savedScore;

  dino_game_sequencer #(
    .JUMP_FRAMES(JF),
    .MIN_GAP    (MG),
    .SPEED_STEP (SS),
    .SPEED_MAX  (SM),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .up         (up),
    .collision  (collision),
    .state      (state),
    .jump_start (jump_start),
    .airborne   (airborne),
    .spawn      (spawn),
    .spawn_kind (spawn_kind),
    .speed      (speed),
    .score      (score)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] packDut();
    return {state, jump_start, airborne, spawn, spawn_kind, speed, score};
  endfunction

  function automatic logic [26:0] packModel();
    return {2'(mState), mJump, mAirborne, mSpawn, 2'(mKind), 4'(mSpeed), 16'(mScore)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mLfsr = int'(SEED); mAir = 0; mCd = MG; mScore = 0; mSpeed = 1; mKind = 0;
    mUpQ = 1'b0; mAirborne = 1'b0; mJump = 1'b0; mSpawn = 1'b0;
    expQ.delete();
  endtask

  // Behavioural game rules, evaluated once per clock edge.
  task automatic modelStep(input logic u, input logic t, input logic c);
    logic rise;
    int   fb;
    rise   = u && !mUpQ;
    mJump  = 1'b0;
    mSpawn = 1'b0;
    if (mState == 1) begin
      if (c) begin
        mState = 2;
      end else begin
        if (rise && !mAirborne) begin
          mJump = 1'b1; mAirborne = 1'b1; mAir = JF;
        end else if (t && mAir > 0) begin
          mAir = mAir - 1;
          if (mAir == 0) mAirborne = 1'b0;
        end
        if (t) begin
          if (mScore < 65535) mScore = mScore + 1;
          mSpeed = 1 + mScore / SS;
          if (mSpeed > SM) mSpeed = SM;
          if (mCd == 0) begin
            mSpawn = 1'b1;
            mKind  = mLfsr % 4;
            if (mKind == 3) mKind = 0;
            mCd = MG + (mLfsr % 32);
          end else begin
            mCd = mCd - 1;
          end
        end
      end
    end else if (mState == 0) begin
      if (rise) begin mState = 1; mScore = 0; mSpeed = 1; mCd = MG; end
    end else begin
      if (rise) mState = 0;
    end
    if (mLfsr == 0) begin
      mLfsr = int'(SEED);
    end else begin
      fb    = ((mLfsr >> 15) ^ (mLfsr >> 13) ^ (mLfsr >> 12) ^ (mLfsr >> 10)) & 1;
      mLfsr = ((mLfsr << 1) | fb) & 32'hFFFF;
    end
    mUpQ = u;
  endtask

  task automatic applyStimulus(input logic u, input logic t, input logic c);
    logic [26:0] e;
    up = u; frame_tick = t; collision = c;
    modelStep(u, t, c);
    expQ.push_back(packModel());
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("cycle", 32'(packDut()), 32'(e));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput(tag, 32'(packDut()), 32'h0001_0000);
  endtask

  initial begin
    rst = 1'b0; up = 1'b0; frame_tick = 1'b0; collision = 1'b0;
    modelReset();
    #12;
    checkResetValues("reset_init");
    rst = 1'b1;

    // Start: the starting press must not also jump.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_state", 32'(state), 32'd1);
    checkOutput("start_nojump", 32'(jump_start), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Jump window of four frames with a re-press ignored mid-air.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("jump_pulse", 32'({jump_start, airborne}), 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("jump_one_cycle", 32'(jump_start), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("jump_ignored", 32'(jump_start), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("air_after3", 32'(airborne), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("air_after4", 32'(airborne), 32'd0);

    // Mid-game reset takes effect without a clock edge.
    #1 rst = 1'b0;
    #1 checkResetValues("reset_mid");
    modelReset();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1 rst = 1'b1;
    modelReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_nojump", 32'({state, jump_start}), 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // 200 frames of spawn cadence, score and speed ramp.
    tickIdx = 0; firstSpawn = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tickIdx++;
      if (spawn) begin
        if (firstSpawn == 0) firstSpawn = tickIdx;
        checkOutput("kind_not3", 32'(spawn_kind == 2'd3), 32'd0);
      end
      if (tickIdx == 3)  checkOutput("speed_at3", 32'(speed), 32'd1);
      if (tickIdx == 4)  checkOutput("speed_at4", 32'(speed), 32'd2);
      if (tickIdx == 8)  checkOutput("speed_at8", 32'(speed), 32'd3);
      if (tickIdx == 20) checkOutput("score_at20", 32'({speed, score}), 32'h3_0014);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("first_spawn", firstSpawn, 32'd41);
    checkOutput("score_200", 32'(score), 32'd200);

    // Collision on the very tick where a spawn is due.
    for (int i = 0; i < 100 && mCd != 0; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    savedScore = mScore;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("coll_state", 32'({state, spawn}), 32'h4);
    checkOutput("coll_score", 32'(score), 32'(savedScore));
    collision = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("done_frozen", 32'({state, score}), {14'd0, 2'd2, 16'(savedScore)});
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("done_to_ini", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("replay", 32'({state, score}), 32'h1_0000);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Score saturation from a preloaded value.
    force dut.score_q = 16'hFFFE;
    #1 release dut.score_q;
    mScore = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("saturate", 32'(score), 32'hFFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
